fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Second instruction-fetch stage. Sits directly downstream of pre_fetch_stage and upstream of the decode-side instruction queue.
- Records the PC pair of every ICache request that pre_fetch_stage issues. Pairs each in-order 64-bit ICache response with its request, then hands two-slot instruction bundles to the queue.
- On flush, discards in-flight ICache responses so stale instructions never reach decode.

Parameters:
- DEPTH, 4, number of in-flight request entries (power of two, ≥2).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and discard counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush. Kills all entries and all outstanding responses.
- pfs_to_valid  in  1  pre_fetch_stage request accepted by the ICache this cycle.
- prefetch_to_fetch_bus1  in  prefetch_to_fetch_bus_t  slot 0 {valid, pc, exception}.
- prefetch_to_fetch_bus2  in  prefetch_to_fetch_bus_t  slot 1 {valid, pc, exception}.
- fs_allowin  out  1  an entry is free; pre_fetch_stage may issue a request.
- icache_data_ok  in  1  one ICache response this cycle, returned in request order.
- icache_rdata  in  64  [31:0] is the instruction at pc+0, [63:32] the instruction at pc+4.
- iq_allowin  in  1  instruction queue can accept two slots.
- fs_to_valid  out  1  bundle presented this cycle.
- fetch_to_iq_bus1  out  fetch_to_iq_bus_t  slot 0 {valid, pc, inst, exception}.
- fetch_to_iq_bus2  out  fetch_to_iq_bus_t  slot 1 {valid, pc, inst, exception}.

Behaviour:
- Storage: circular entry array with alloc_ptr, fill_ptr, head_ptr, count, and discard_cnt.
  - Each entry holds: bus1, bus2, rdata, filled.
- Allocate: when pfs_to_valid && !flush, write both buses into entry[alloc_ptr], clear filled, increment alloc_ptr and count.
- Fill: when icache_data_ok:
  - if discard_cnt != 0, decrement discard_cnt and drop the data;
  - otherwise write rdata into entry[fill_ptr], set filled, increment fill_ptr.
- Pop: when fs_to_valid && iq_allowin, increment head_ptr and decrement count.
  - Allocate and pop in the same cycle leave count unchanged.
- fs_to_valid = count != 0 && entry[head_ptr].filled && !flush. This is zero-latency from the register; the earliest output is the cycle after data_ok.
- Output slots:
  - fetch_to_iq_busN.valid = fs_to_valid && entry.busN.valid.
  - inst comes from the matching rdata half; pc and exception pass through.
  - Slot 0 is invalid when the request pc[2]=1 (branch target in the odd slot).
- fs_allowin = count < DEPTH. When full, no allocation; pfs_to_valid asserted while full is an assertion failure.
- Flush cycle:
  - count, head_ptr, fill_ptr and alloc_ptr all reset to 0, and all filled bits clear.
  - discard_cnt <= (number of allocated-but-unfilled entries) minus (1 if icache_data_ok with discard_cnt==0 this cycle), plus the existing discard_cnt minus (1 if data_ok consumed a discard).
  - Allocation and output are suppressed that cycle.
- New requests are allowed while discard_cnt != 0. Their responses arrive after the discarded ones, so ordering holds.
- Pointers wrap modulo DEPTH.
- Reset: count, all pointers and discard_cnt = 0; filled = 0; fs_to_valid = 0; fs_allowin = 1; all output valid bits = 0. A reset mid-operation drops everything; the ICache is reset in the same cycle.
- icache_data_ok with no unfilled entry and discard_cnt==0 is an assertion failure.

Decomposition:
- Shared cpu package (cpu.svh) holds:
  - prefetch_to_fetch_bus_t (existing);
  - new fetch_to_iq_bus_t {valid, pc virt_t, inst 32b, exception};
  - exception type (existing).
- One natural sub-module: fetch_entry_queue (circular array plus the three pointers). fetch_stage keeps the discard counter, flush handling and output formatting.

Test Plan:
- Single request, pc=0xbfc00000: pfs_to_valid, then data_ok 2 cycles later with rdata=0x2402000124010002 -> next cycle both slots valid, slot0 pc 0xbfc00000 inst 0x24010002, slot1 pc 0xbfc00004 inst 0x24020001.
- Odd-slot target pc=0xbfc00014: bus1.valid=0 -> only bus2 valid, pc 0xbfc00014, inst = rdata[63:32].
- Backpressure: iq_allowin=0 while issuing 4 requests and returning all data -> fs_allowin drops to 0 after the 4th; raise iq_allowin -> 4 bundles leave in order, fs_allowin returns to 1.
- Flush with 3 outstanding requests, then 3 data_ok plus a new request -> the 3 responses are dropped, discard_cnt ends 0, and the 4th response is output with the new PC.
- Flush in the same cycle as data_ok with 2 outstanding -> discard_cnt=1; the next data_ok is dropped and nothing is output.
- Reset asserted with 2 filled entries -> next cycle fs_to_valid=0, fs_allowin=1, count=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side types: request/response slot buses and the exception record.
// The helper builds one decode-queue slot from a stored request slot and its instruction word.
package fetch_stage_pkg;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic       excp;
    logic [4:0] ecode;
  } exception_t;

  typedef struct packed {
    logic       valid;
    virt_t      pc;
    exception_t exception;
  } prefetch_to_fetch_bus_t;

  typedef struct packed {
    logic        valid;
    virt_t       pc;
    logic [31:0] inst;
    exception_t  exception;
  } fetch_to_iq_bus_t;

  function automatic fetch_to_iq_bus_t make_iq_slot(input logic                   en,
                                                    input prefetch_to_fetch_bus_t req,
                                                    input logic [31:0]            inst);
    fetch_to_iq_bus_t slot;
    slot.valid     = en && req.valid;
    slot.pc        = req.pc;
    slot.inst      = inst;
    slot.exception = req.exception;
    return slot;
  endfunction

endpackage

// File: rtl/fetch_entry_queue.sv
// Circular array of in-flight fetch requests with allocate, fill and pop pointers.
// Also tracks occupancy and how many allocated entries still wait for ICache data.
module fetch_entry_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   alloc_en,
  input  prefetch_to_fetch_bus_t alloc_bus1,
  input  prefetch_to_fetch_bus_t alloc_bus2,
  input  logic                   fill_en,
  input  logic [63:0]            fill_rdata,
  input  logic                   pop_en,
  output prefetch_to_fetch_bus_t head_bus1,
  output prefetch_to_fetch_bus_t head_bus2,
  output logic [63:0]            head_rdata,
  output logic                   head_filled,
  output logic [CNT_W-1:0]       count,
  output logic [CNT_W-1:0]       pending
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       alloc_ptr_r;
  logic [PTR_W-1:0]       fill_ptr_r;
  logic [PTR_W-1:0]       head_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       pending_r;
  logic [DEPTH-1:0]       filled_r;
  prefetch_to_fetch_bus_t bus1_mem_r [DEPTH];
  prefetch_to_fetch_bus_t bus2_mem_r [DEPTH];
  logic [63:0]            rdata_mem_r [DEPTH];

  // Pointers, counters and filled flags; flush empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alloc_ptr_r <= {PTR_W{1'b0}};
      fill_ptr_r  <= {PTR_W{1'b0}};
      head_ptr_r  <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      pending_r   <= {CNT_W{1'b0}};
      filled_r    <= {DEPTH{1'b0}};
    end else begin
      if (alloc_en) begin
        filled_r[alloc_ptr_r] <= 1'b0;
        alloc_ptr_r           <= alloc_ptr_r + PTR_W'(1);
      end
      if (fill_en) begin
        filled_r[fill_ptr_r] <= 1'b1;
        fill_ptr_r           <= fill_ptr_r + PTR_W'(1);
      end
      if (pop_en) begin
        head_ptr_r <= head_ptr_r + PTR_W'(1);
      end
      count_r   <= count_r + CNT_W'(alloc_en) - CNT_W'(pop_en);
      pending_r <= pending_r + CNT_W'(alloc_en) - CNT_W'(fill_en);
    end
  end

  // Payload storage; contents of unused entries are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (alloc_en && !flush) begin
      bus1_mem_r[alloc_ptr_r] <= alloc_bus1;
      bus2_mem_r[alloc_ptr_r] <= alloc_bus2;
    end
    if (fill_en && !flush) begin
      rdata_mem_r[fill_ptr_r] <= fill_rdata;
    end
  end

  assign head_bus1   = bus1_mem_r[head_ptr_r];
  assign head_bus2   = bus2_mem_r[head_ptr_r];
  assign head_rdata  = rdata_mem_r[head_ptr_r];
  assign head_filled = filled_r[head_ptr_r];
  assign count       = count_r;
  assign pending     = pending_r;

endmodule

// File: rtl/fetch_stage_checker.sv
// Protocol checks on the fetch stage boundary: no request into a full stage and
// no ICache response while nothing is outstanding.
module fetch_stage_checker #(
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             reset,
  input logic             pfs_to_valid,
  input logic             fs_allowin,
  input logic             icache_data_ok,
  input logic [CNT_W-1:0] pending,
  input logic [CNT_W-1:0] discard_cnt
);

  // Upstream must respect fs_allowin.
  a_no_alloc_when_full : assert property (@(posedge clk) disable iff (reset)
    !(pfs_to_valid && !fs_allowin))
    else $error("fetch_stage: request issued while full");

  // Every response must match either a discard or an allocated, unfilled entry.
  a_no_orphan_response : assert property (@(posedge clk) disable iff (reset)
    !(icache_data_ok && (pending == {CNT_W{1'b0}}) && (discard_cnt == {CNT_W{1'b0}})))
    else $error("fetch_stage: response with nothing outstanding");

endmodule

// File: rtl/fetch_stage.sv
// Second fetch stage: pairs in-order ICache responses with recorded requests and
// presents two-slot bundles to the instruction queue, discarding responses killed by flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   pfs_to_valid,
  input  prefetch_to_fetch_bus_t prefetch_to_fetch_bus1,
  input  prefetch_to_fetch_bus_t prefetch_to_fetch_bus2,
  output logic                   fs_allowin,
  input  logic                   icache_data_ok,
  input  logic [63:0]            icache_rdata,
  input  logic                   iq_allowin,
  output logic                   fs_to_valid,
  output fetch_to_iq_bus_t       fetch_to_iq_bus1,
  output fetch_to_iq_bus_t       fetch_to_iq_bus2
);

  logic [CNT_W-1:0]       count_s;
  logic [CNT_W-1:0]       pending_s;
  logic [CNT_W-1:0]       discard_cnt_r;
  prefetch_to_fetch_bus_t head_bus1_s;
  prefetch_to_fetch_bus_t head_bus2_s;
  logic [63:0]            head_rdata_s;
  logic                   head_filled_s;
  logic                   fs_valid_s;
  logic                   alloc_en_s;
  logic                   fill_en_s;
  logic                   pop_en_s;
  logic                   discard_hit_s;

  assign fs_allowin    = (count_s < CNT_W'(DEPTH));
  assign fs_valid_s    = (count_s != {CNT_W{1'b0}}) && head_filled_s && !flush;
  assign discard_hit_s = icache_data_ok && (discard_cnt_r != {CNT_W{1'b0}});
  assign alloc_en_s    = pfs_to_valid && !flush && fs_allowin;
  assign fill_en_s     = icache_data_ok && (discard_cnt_r == {CNT_W{1'b0}}) && !flush;
  assign pop_en_s      = fs_valid_s && iq_allowin;

  fetch_entry_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_en    (alloc_en_s),
    .alloc_bus1  (prefetch_to_fetch_bus1),
    .alloc_bus2  (prefetch_to_fetch_bus2),
    .fill_en     (fill_en_s),
    .fill_rdata  (icache_rdata),
    .pop_en      (pop_en_s),
    .head_bus1   (head_bus1_s),
    .head_bus2   (head_bus2_s),
    .head_rdata  (head_rdata_s),
    .head_filled (head_filled_s),
    .count       (count_s),
    .pending     (pending_s)
  );

  // Responses still owed by the ICache for killed requests: on flush every unfilled
  // entry joins the backlog, and this cycle's response (if any) pays one back.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      discard_cnt_r <= discard_cnt_r + pending_s - CNT_W'(icache_data_ok);
    end else if (discard_hit_s) begin
      discard_cnt_r <= discard_cnt_r - CNT_W'(1);
    end
  end

  assign fs_to_valid = fs_valid_s;
  // A request whose slot-0 pc sits in the odd word is a branch into slot 1.
  assign fetch_to_iq_bus1 = make_iq_slot(fs_valid_s && !head_bus1_s.pc[2], head_bus1_s,
                                         head_rdata_s[31:0]);
  assign fetch_to_iq_bus2 = make_iq_slot(fs_valid_s, head_bus2_s, head_rdata_s[63:32]);

  fetch_stage_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .pfs_to_valid   (pfs_to_valid),
    .fs_allowin     (fs_allowin),
    .icache_data_ok (icache_data_ok),
    .pending        (pending_s),
    .discard_cnt    (discard_cnt_r)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// backpressure/reset sequences, and randomized traffic against a queue-based model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   pfs_to_valid;
  prefetch_to_fetch_bus_t prefetch_to_fetch_bus1;
  prefetch_to_fetch_bus_t prefetch_to_fetch_bus2;
  logic                   fs_allowin;
  logic                   icache_data_ok;
  logic [63:0]            icache_rdata;
  logic                   iq_allowin;
  logic                   fs_to_valid;
  fetch_to_iq_bus_t       fetch_to_iq_bus1;
  fetch_to_iq_bus_t       fetch_to_iq_bus2;

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .flush                  (flush),
    .pfs_to_valid           (pfs_to_valid),
    .prefetch_to_fetch_bus1 (prefetch_to_fetch_bus1),
    .prefetch_to_fetch_bus2 (prefetch_to_fetch_bus2),
    .fs_allowin             (fs_allowin),
    .icache_data_ok         (icache_data_ok),
    .icache_rdata           (icache_rdata),
    .iq_allowin             (iq_allowin),
    .fs_to_valid            (fs_to_valid),
    .fetch_to_iq_bus1       (fetch_to_iq_bus1),
    .fetch_to_iq_bus2       (fetch_to_iq_bus2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream convention: an odd-word target clears slot 0 and puts the target pc in slot 1.
  task automatic drive(input bit rst, input bit fl, input bit pfs, input logic [31:0] pc,
                       input bit dok, input logic [63:0] rd, input bit iqa,
                       input exception_t exc);
    reset                            = rst;
    flush                            = fl;
    pfs_to_valid                     = pfs;
    prefetch_to_fetch_bus1.valid     = ~pc[2];
    prefetch_to_fetch_bus1.pc        = {pc[31:3], 3'b000};
    prefetch_to_fetch_bus1.exception = exc;
    prefetch_to_fetch_bus2.valid     = 1'b1;
    prefetch_to_fetch_bus2.pc        = {pc[31:3], 3'b100};
    prefetch_to_fetch_bus2.exception = exc;
    icache_data_ok                   = dok;
    icache_rdata                     = rd;
    iq_allowin                       = iqa;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          fl;
    bit          pfs;
    logic [31:0] pc;
    bit          dok;
    logic [63:0] rd;
    bit          e_fsv;
    bit          e_allow;
    bit          e_v1;
    bit          e_v2;
    logic [31:0] e_pc1;
    logic [31:0] e_i1;
    logic [31:0] e_pc2;
    logic [31:0] e_i2;
  } vec_t;

  function automatic vec_t vr(bit fl, bit pfs, logic [31:0] pc, bit dok, logic [63:0] rd,
                              bit fsv, bit allow, bit v1, bit v2, logic [31:0] pc1,
                              logic [31:0] i1, logic [31:0] pc2, logic [31:0] i2);
    vec_t v;
    v.fl = fl; v.pfs = pfs; v.pc = pc; v.dok = dok; v.rd = rd;
    v.e_fsv = fsv; v.e_allow = allow; v.e_v1 = v1; v.e_v2 = v2;
    v.e_pc1 = pc1; v.e_i1 = i1; v.e_pc2 = pc2; v.e_i2 = i2;
    return v;
  endfunction

  function automatic vec_t idle();
    return vr(0, 0, 32'h0, 0, 64'h0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic vec_t req(logic [31:0] pc);
    return vr(0, 1, pc, 0, 64'h0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic vec_t rsp(logic [63:0] rd);
    return vr(0, 0, 32'h0, 1, rd, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  // Reference model: outstanding requests in program order plus a count of owed discards.
  typedef struct {
    prefetch_to_fetch_bus_t b1;
    prefetch_to_fetch_bus_t b2;
    logic [63:0]            rd;
    bit                     filled;
  } ment_t;

  ment_t mq[$];
  int    mdisc;

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  vec_t           vecs[$];
  exception_t     no_exc;
  logic [31:0]    pcs[4];

  initial begin
    no_exc = '0;

    drive(1, 0, 0, 32'h0, 0, 64'h0, 1, no_exc);
    tick;
    tick;
    drive(0, 0, 0, 32'h0, 0, 64'h0, 1, no_exc);
    @(negedge clk);
    chk("reset_state", {fs_to_valid, fs_allowin, fetch_to_iq_bus1.valid, fetch_to_iq_bus2.valid},
        {1'b0, 1'b1, 1'b0, 1'b0});
    tick;

    // Single request, odd-slot target, flush with a response in the same cycle,
    // flush with three outstanding followed by a fresh request.
    vecs.push_back(req(32'hbfc00000));
    vecs.push_back(idle());
    vecs.push_back(rsp(64'h2402000124010002));
    vecs.push_back(vr(0, 0, 32'h0, 0, 64'h0, 1, 1, 1, 1,
                      32'hbfc00000, 32'h24010002, 32'hbfc00004, 32'h24020001));
    vecs.push_back(idle());
    vecs.push_back(req(32'hbfc00014));
    vecs.push_back(rsp(64'h8c4400048c430000));
    vecs.push_back(vr(0, 0, 32'h0, 0, 64'h0, 1, 1, 0, 1,
                      32'h0, 32'h0, 32'hbfc00014, 32'h8c440004));
    vecs.push_back(idle());
    vecs.push_back(req(32'hbfc00100));
    vecs.push_back(req(32'hbfc00108));
    vecs.push_back(vr(1, 0, 32'h0, 1, 64'haaaaaaaaaaaaaaaa, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(rsp(64'hbbbbbbbbbbbbbbbb));
    vecs.push_back(idle());
    vecs.push_back(req(32'hbfc00200));
    vecs.push_back(rsp(64'h0000000d0000000c));
    vecs.push_back(vr(0, 0, 32'h0, 0, 64'h0, 1, 1, 1, 1,
                      32'hbfc00200, 32'h0000000c, 32'hbfc00204, 32'h0000000d));
    vecs.push_back(req(32'hbfc00300));
    vecs.push_back(req(32'hbfc00308));
    vecs.push_back(req(32'hbfc00310));
    vecs.push_back(vr(1, 0, 32'h0, 0, 64'h0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(vr(0, 1, 32'hbfc00400, 1, 64'h1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(rsp(64'h2));
    vecs.push_back(rsp(64'h3));
    vecs.push_back(rsp(64'h0000002200000011));
    vecs.push_back(vr(0, 0, 32'h0, 0, 64'h0, 1, 1, 1, 1,
                      32'hbfc00400, 32'h00000011, 32'hbfc00404, 32'h00000022));
    vecs.push_back(idle());

    foreach (vecs[i]) begin
      drive(0, vecs[i].fl, vecs[i].pfs, vecs[i].pc, vecs[i].dok, vecs[i].rd, 1, no_exc);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          {fs_to_valid, fs_allowin, fetch_to_iq_bus1.valid, fetch_to_iq_bus2.valid},
          {vecs[i].e_fsv, vecs[i].e_allow, vecs[i].e_v1, vecs[i].e_v2});
      if (vecs[i].e_v1)
        chk($sformatf("vec%0d_slot0", i), {fetch_to_iq_bus1.pc, fetch_to_iq_bus1.inst},
            {vecs[i].e_pc1, vecs[i].e_i1});
      if (vecs[i].e_v2)
        chk($sformatf("vec%0d_slot1", i), {fetch_to_iq_bus2.pc, fetch_to_iq_bus2.inst},
            {vecs[i].e_pc2, vecs[i].e_i2});
      tick;
    end

    // Backpressure: fill all four entries while the queue refuses, then drain in order.
    for (int k = 0; k < 4; k++) begin
      pcs[k] = 32'hbfc01000 + 32'(k * 8);
      drive(0, 0, 1, pcs[k], 0, 64'h0, 0, no_exc);
      @(negedge clk);
      chk($sformatf("bp_allow%0d", k), fs_allowin, 1'b1);
      tick;
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 32'h0, 1, {pcs[k] + 32'h4, pcs[k]}, 0, no_exc);
      @(negedge clk);
      chk($sformatf("bp_full%0d", k), fs_allowin, 1'b0);
      tick;
    end
    drive(0, 0, 0, 32'h0, 0, 64'h0, 0, no_exc);
    @(negedge clk);
    chk("bp_hold", {fs_to_valid, fetch_to_iq_bus1.pc}, {1'b1, pcs[0]});
    tick;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 32'h0, 0, 64'h0, 1, no_exc);
      @(negedge clk);
      chk($sformatf("bp_drain%0d", k),
          {fs_to_valid, fetch_to_iq_bus1.pc, fetch_to_iq_bus1.inst,
           fetch_to_iq_bus2.pc, fetch_to_iq_bus2.inst},
          {1'b1, pcs[k], pcs[k], pcs[k] + 32'h4, pcs[k] + 32'h4});
      tick;
    end
    @(negedge clk);
    chk("bp_empty", {fs_to_valid, fs_allowin}, {1'b0, 1'b1});
    tick;

    // Reset with two filled entries waiting behind backpressure.
    drive(0, 0, 1, 32'hbfc02000, 0, 64'h0, 0, no_exc); tick;
    drive(0, 0, 1, 32'hbfc02008, 0, 64'h0, 0, no_exc); tick;
    drive(0, 0, 0, 32'h0, 1, 64'h1, 0, no_exc); tick;
    drive(0, 0, 0, 32'h0, 1, 64'h2, 0, no_exc); tick;
    drive(1, 0, 0, 32'h0, 0, 64'h0, 0, no_exc); tick;
    drive(0, 0, 0, 32'h0, 0, 64'h0, 1, no_exc);
    @(negedge clk);
    chk("rst_mid", {fs_to_valid, fs_allowin}, {1'b0, 1'b1});
    tick;
    drive(0, 0, 1, 32'hbfc03000, 0, 64'h0, 1, no_exc); tick;
    drive(0, 0, 0, 32'h0, 1, 64'h0000007700000066, 1, no_exc); tick;
    drive(0, 0, 0, 32'h0, 0, 64'h0, 1, no_exc);
    @(negedge clk);
    chk("rst_after", {fs_to_valid, fetch_to_iq_bus1.pc, fetch_to_iq_bus2.inst},
        {1'b1, 32'hbfc03000, 32'h00000077});
    tick;
    tick;

    // Randomized traffic against the model, starting from a clean reset.
    drive(1, 0, 0, 32'h0, 0, 64'h0, 1, no_exc);
    tick;
    mq.delete();
    mdisc = 0;
    for (int n = 0; n < 3000; n++) begin
      int          unf;
      bit          rst, fl, pfs, dok, iqa, e_fsv, e_v1, e_v2;
      logic [31:0] r32;
      logic [63:0] rd;
      exception_t  exc;
      unf  = m_unfilled();
      rst  = ($urandom_range(0, 299) == 0);
      fl   = !rst && ($urandom_range(0, 19) == 0) && (mdisc + unf <= 6);
      pfs  = !rst && !fl && (mq.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      dok  = !rst && (mdisc + unf > 0) && ($urandom_range(0, 1) == 1);
      iqa  = ($urandom_range(0, 3) != 0);
      r32  = $urandom();
      rd   = {$urandom(), $urandom()};
      exc  = exception_t'($urandom_range(0, 63));
      drive(rst, fl, pfs, {r32[31:2], 2'b00}, dok, rd, iqa, exc);
      @(negedge clk);
      e_fsv = !fl && (mq.size() > 0) && mq[0].filled;
      e_v1  = e_fsv && mq[0].b1.valid && !mq[0].b1.pc[2];
      e_v2  = e_fsv && mq[0].b2.valid;
      chk($sformatf("rnd%0d_ctl", n),
          {fs_to_valid, fs_allowin, fetch_to_iq_bus1.valid, fetch_to_iq_bus2.valid},
          {e_fsv, mq.size() < DEPTH, e_v1, e_v2});
      if (e_v1)
        chk($sformatf("rnd%0d_slot0", n),
            {fetch_to_iq_bus1.pc, fetch_to_iq_bus1.inst, fetch_to_iq_bus1.exception},
            {mq[0].b1.pc, mq[0].rd[31:0], mq[0].b1.exception});
      if (e_v2)
        chk($sformatf("rnd%0d_slot1", n),
            {fetch_to_iq_bus2.pc, fetch_to_iq_bus2.inst, fetch_to_iq_bus2.exception},
            {mq[0].b2.pc, mq[0].rd[63:32], mq[0].b2.exception});
      if (rst) begin
        mq.delete();
        mdisc = 0;
      end else if (fl) begin
        mdisc = mdisc + unf - int'(dok);
        mq.delete();
      end else begin
        if (dok) begin
          if (mdisc > 0) mdisc--;
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                mq[i].filled = 1'b1;
                mq[i].rd     = rd;
                break;
              end
            end
          end
        end
        if (e_fsv && iqa) void'(mq.pop_front());
        if (pfs) begin
          ment_t e;
          e.b1 = prefetch_to_fetch_bus1;
          e.b2 = prefetch_to_fetch_bus2;
          e.rd = 64'h0;
          e.filled = 1'b0;
          mq.push_back(e);
        end
      end
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
